// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative data-cache array with true-LRU and flush engine
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   addr_i, tag_i, data_i          lookup set, {valid, dirty, tag} word, line write data
//   enable_i, write_i              access request, 1 = write/fill, 0 = read
//   flush_i                        start a walk that writes back every dirty line
//   tag_o, data_o, hit_o, way_o    lookup result: hit way, or the victim on a miss
//   busy_o                         flush walk in progress
//   wb_valid_o, wb_ready_i         write-back handshake
//   wb_tag_o, wb_set_o, wb_data_o  write-back payload
//   flush_done_o                   one-cycle pulse at the end of a walk

module dcache_sram_nway #(
  parameter  int NUM_SETS = 16,
  parameter  int NUM_WAYS = 4,
  parameter  int TAG_W    = 23,
  parameter  int LINE_W   = 256,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W+1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              flush_i,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic              busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [IDX_W-1:0]  wb_set_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic              flush_done_o
);

  localparam int VALID_BIT = TAG_W + 1;
  localparam int DIRTY_BIT = TAG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cur_set_q, cur_set_d;
  logic [WAY_W-1:0]  cur_way_q, cur_way_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [TAG_W+1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W+1:0]  tag_d  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_d [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  rank_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  rank_d [NUM_SETS][NUM_WAYS];

  // The valid bit of the incoming tag word carries no meaning for an access.
  logic unused_tag_valid;
  assign unused_tag_valid = tag_i[VALID_BIT];

  // ---------------------------------------------------------------- lookup
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             has_invalid;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] sel_way;

  // Ways are scanned high to low so the lowest matching index wins.
  always_comb begin
    hit_any     = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    lru_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (tag_q[addr_i][w][VALID_BIT] &&
          (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!tag_q[addr_i][w][VALID_BIT]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
      if (rank_q[addr_i][w] == WAY_W'(NUM_WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
    if (hit_any) begin
      sel_way = hit_way;
    end else if (has_invalid) begin
      sel_way = inv_way;
    end else begin
      sel_way = lru_way;
    end
  end

  // Lookup outputs are forced to zero while reset is asserted.
  assign hit_o  = hit_any && !busy_q && !rst_i;
  assign way_o  = rst_i ? '0 : sel_way;
  assign tag_o  = rst_i ? '0 : tag_q[addr_i][sel_way];
  assign data_o = rst_i ? '0 : data_q[addr_i][sel_way];

  assign busy_o       = busy_q;
  assign wb_valid_o   = (state_q == S_WB);
  assign flush_done_o = done_q;
  assign wb_tag_o     = tag_q[cur_set_q][cur_way_q][TAG_W-1:0];
  assign wb_set_o     = cur_set_q;
  assign wb_data_o    = data_q[cur_set_q][cur_way_q];

  // ---------------------------------------------------------- array update
  logic             access;
  logic             touch;
  logic [WAY_W-1:0] old_rank;

  assign access = enable_i && !busy_q;

  always_comb begin
    tag_d    = tag_q;
    data_d   = data_q;
    rank_d   = rank_q;
    touch    = 1'b0;
    old_rank = rank_q[addr_i][sel_way];

    if (access) begin
      if (write_i) begin
        tag_d[addr_i][sel_way]  = {1'b1, tag_i[DIRTY_BIT], tag_i[TAG_W-1:0]};
        data_d[addr_i][sel_way] = data_i;
        touch                   = 1'b1;
      end else if (hit_any) begin
        touch = 1'b1;
      end
    end

    // Move the touched way to MRU; only ways that were more recent than it
    // age by one, which keeps the ranks a permutation.
    if (touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == sel_way) begin
          rank_d[addr_i][w] = '0;
        end else if (rank_q[addr_i][w] < old_rank) begin
          rank_d[addr_i][w] = rank_q[addr_i][w] + WAY_W'(1);
        end
      end
    end

    // Accepted write-back: the line stays resident, only the dirty bit drops.
    if ((state_q == S_WB) && wb_ready_i) begin
      tag_d[cur_set_q][cur_way_q][DIRTY_BIT] = 1'b0;
    end
  end

  // ---------------------------------------------------------- flush walk
  logic             last_entry;
  logic             entry_dirty;
  logic [IDX_W-1:0] nxt_set;
  logic [WAY_W-1:0] nxt_way;

  assign last_entry  = (cur_set_q == IDX_W'(NUM_SETS - 1)) &&
                       (cur_way_q == WAY_W'(NUM_WAYS - 1));
  assign entry_dirty = tag_q[cur_set_q][cur_way_q][VALID_BIT] &&
                       tag_q[cur_set_q][cur_way_q][DIRTY_BIT];

  // Cursor walks ways first, then sets.
  always_comb begin
    if (cur_way_q == WAY_W'(NUM_WAYS - 1)) begin
      nxt_way = '0;
      nxt_set = cur_set_q + IDX_W'(1);
    end else begin
      nxt_way = cur_way_q + WAY_W'(1);
      nxt_set = cur_set_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_set_d = cur_set_q;
    cur_way_d = cur_way_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d   = S_SCAN;
          cur_set_d = '0;
          cur_way_d = '0;
        end
      end
      S_SCAN: begin
        if (entry_dirty) begin
          state_d = S_WB;
        end else if (last_entry) begin
          state_d = S_IDLE;
        end else begin
          cur_set_d = nxt_set;
          cur_way_d = nxt_way;
        end
      end
      S_WB: begin
        if (wb_ready_i) begin
          if (last_entry) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_SCAN;
            cur_set_d = nxt_set;
            cur_way_d = nxt_way;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cur_set_q <= '0;
      cur_way_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          rank_q[s][w] <= WAY_W'(NUM_WAYS - 1 - w);
        end
      end
    end else begin
      state_q   <= state_d;
      cur_set_q <= cur_set_d;
      cur_way_q <= cur_way_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      rank_q    <= rank_d;
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - directed self-checking bench for dcache_sram_nway

module tb_dcache_sram_nway;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   addr = '0;
  logic [24:0]  tag_in = '0;
  logic [255:0] data_in = '0;
  logic         enable = 1'b0;
  logic         write = 1'b0;
  logic         flush = 1'b0;
  logic         wb_ready = 1'b1;
  logic [24:0]  tag_o;
  logic [255:0] data_o;
  logic         hit_o;
  logic [1:0]   way_o;
  logic         busy_o;
  logic         wb_valid_o;
  logic [22:0]  wb_tag_o;
  logic [3:0]   wb_set_o;
  logic [255:0] wb_data_o;
  logic         flush_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]   hs_set  [4];
  logic [22:0]  hs_tag  [4];
  logic [255:0] hs_data [4];

  localparam logic [255:0] DA  = {8{32'hA0A0_0001}};
  localparam logic [255:0] DB  = {8{32'hB0B0_0002}};
  localparam logic [255:0] DC  = {8{32'hC0C0_0003}};
  localparam logic [255:0] DD  = {8{32'hD0D0_0004}};
  localparam logic [255:0] DE  = {8{32'hE0E0_0005}};
  localparam logic [255:0] DF  = {8{32'hF0F0_0006}};
  localparam logic [255:0] DX  = {8{32'h1234_5678}};
  localparam logic [255:0] DY  = {8{32'h8765_4321}};
  localparam logic [255:0] DX2 = {8{32'h5A5A_A5A5}};
  localparam logic [255:0] DZ  = {8{32'hDEAD_BEEF}};

  dcache_sram_nway dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .tag_i(tag_in), .data_i(data_in),
    .enable_i(enable), .write_i(write), .flush_i(flush),
    .tag_o(tag_o), .data_o(data_o), .hit_o(hit_o), .way_o(way_o),
    .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready),
    .wb_tag_o(wb_tag_o), .wb_set_o(wb_set_o), .wb_data_o(wb_data_o),
    .flush_done_o(flush_done_o)
  );

  always #5 clk = ~clk;

  task automatic lookup(input logic [3:0] s, input logic [22:0] t);
    @(negedge clk);
    addr = s; tag_in = {2'b00, t}; enable = 1'b0; write = 1'b0;
    #1;
  endtask

  task automatic access(input logic [3:0] s, input logic [22:0] t, input logic d,
                        input logic [255:0] dat, input logic wr);
    @(negedge clk);
    addr = s; tag_in = {1'b0, d, t}; data_in = dat; write = wr; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; write = 1'b0;
  endtask

  task automatic pulse_flush;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  // Watches a walk for a fixed window; stall_n ready-low cycles per offered line.
  task automatic watch_flush(input int stall_n, output int busy_cnt, output int hs_cnt,
                             output int done_cnt, output int unstable, output int hit_busy);
    int stalls;
    logic have;
    logic [3:0] s0; logic [22:0] t0; logic [255:0] d0;
    busy_cnt = 0; hs_cnt = 0; done_cnt = 0; unstable = 0; hit_busy = 0;
    stalls = 0; have = 1'b0; s0 = '0; t0 = '0; d0 = '0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (busy_o && hit_o) hit_busy++;
      if (flush_done_o) done_cnt++;
      if (!busy_o) enable = 1'b0;
      wb_ready = (stall_n == 0);
      if (wb_valid_o) begin
        if (!have) begin
          s0 = wb_set_o; t0 = wb_tag_o; d0 = wb_data_o; have = 1'b1;
        end else if ({s0, t0, d0} !== {wb_set_o, wb_tag_o, wb_data_o}) begin
          unstable++;
        end
        if (stalls < stall_n) stalls++;
        else wb_ready = 1'b1;
        if (wb_ready) begin
          if (hs_cnt < 4) begin
            hs_set[hs_cnt] = wb_set_o; hs_tag[hs_cnt] = wb_tag_o; hs_data[hs_cnt] = wb_data_o;
          end
          hs_cnt++; have = 1'b0; stalls = 0;
        end
      end
    end
    wb_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy_o); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0h want 0", wb_valid_o); end
    n_checks++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", flush_done_o); end
    n_checks++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0h want 0", hit_o); end
    rst = 1'b0;
    lookup(4'd3, 23'h12);
    n_checks++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL empty_hit: got %0h want 0", hit_o); end
    n_checks++; if (way_o !== 2'd0) begin n_fail++; $display("FAIL empty_way: got %0h want 0", way_o); end
    n_checks++; if (tag_o !== 25'h0) begin n_fail++; $display("FAIL empty_tag: got %0h want 0", tag_o); end
    n_checks++; if (data_o !== 256'h0) begin n_fail++; $display("FAIL empty_data: got %0h want 0", data_o); end
  endtask

  task automatic test_fill;
    logic [255:0] dv [4];
    dv[0] = DA; dv[1] = DB; dv[2] = DC; dv[3] = DD;
    for (int i = 0; i < 4; i++) begin
      lookup(4'd5, 23'(i + 1));
      n_checks++; if ({hit_o, way_o} !== {1'b0, 2'(i)}) begin n_fail++; $display("FAIL fill_victim%0d: got hit=%0h way=%0h want hit=0 way=%0d", i, hit_o, way_o, i); end
      access(4'd5, 23'(i + 1), 1'b0, dv[i], 1'b1);
    end
    lookup(4'd5, 23'h1);
    n_checks++; if ({hit_o, way_o} !== 3'b100) begin n_fail++; $display("FAIL fill_hit1: got hit=%0h way=%0h want hit=1 way=0", hit_o, way_o); end
    n_checks++; if (data_o !== DA) begin n_fail++; $display("FAIL fill_data1: got %0h want %0h", data_o, DA); end
    n_checks++; if (tag_o !== {2'b10, 23'h1}) begin n_fail++; $display("FAIL fill_tag1: got %0h want %0h", tag_o, {2'b10, 23'h1}); end
    for (int i = 1; i < 4; i++) begin
      lookup(4'd5, 23'(i + 1));
      n_checks++; if ({hit_o, way_o} !== {1'b1, 2'(i)}) begin n_fail++; $display("FAIL fill_hit%0d: got hit=%0h way=%0h want hit=1 way=%0d", i + 1, hit_o, way_o, i); end
    end
    access(4'd5, 23'h1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_lru;
    lookup(4'd5, 23'h5);
    n_checks++; if ({hit_o, way_o} !== 3'b001) begin n_fail++; $display("FAIL lru_victim: got hit=%0h way=%0h want hit=0 way=1", hit_o, way_o); end
    n_checks++; if (tag_o !== {2'b10, 23'h2}) begin n_fail++; $display("FAIL lru_victim_tag: got %0h want %0h", tag_o, {2'b10, 23'h2}); end
    access(4'd5, 23'h5, 1'b0, DE, 1'b1);
    lookup(4'd5, 23'h1);
    n_checks++; if ({hit_o, way_o, data_o} !== {1'b1, 2'd0, DA}) begin n_fail++; $display("FAIL lru_keep1: got hit=%0h way=%0h want hit=1 way=0 data A", hit_o, way_o); end
    lookup(4'd5, 23'h5);
    n_checks++; if ({hit_o, way_o, data_o} !== {1'b1, 2'd1, DE}) begin n_fail++; $display("FAIL lru_hit5: got hit=%0h way=%0h want hit=1 way=1 data E", hit_o, way_o); end
    lookup(4'd5, 23'h2);
    n_checks++; if ({hit_o, way_o} !== 3'b010) begin n_fail++; $display("FAIL lru_evicted2: got hit=%0h way=%0h want hit=0 way=2", hit_o, way_o); end
    access(4'd5, 23'h9, 1'b0, '0, 1'b0);
    lookup(4'd5, 23'h9);
    n_checks++; if ({hit_o, way_o} !== 3'b010) begin n_fail++; $display("FAIL lru_readmiss: got hit=%0h way=%0h want hit=0 way=2", hit_o, way_o); end
    access(4'd5, 23'h3, 1'b0, '0, 1'b0);
    lookup(4'd5, 23'h2);
    n_checks++; if ({hit_o, way_o} !== 3'b011) begin n_fail++; $display("FAIL lru_after_touch3: got hit=%0h way=%0h want hit=0 way=3", hit_o, way_o); end
  endtask

  task automatic test_back_to_back;
    int b, h, d, u, hb;
    @(negedge clk);
    addr = 4'd2; tag_in = {2'b01, 23'h44}; data_in = DF; write = 1'b1; enable = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; write = 1'b0; flush = 1'b0;
    watch_flush(0, b, h, d, u, hb);
    n_checks++; if (b !== 65) begin n_fail++; $display("FAIL b2b_busy: got %0d want 65", b); end
    n_checks++; if (h !== 1) begin n_fail++; $display("FAIL b2b_hs_count: got %0d want 1", h); end
    n_checks++; if ({hs_set[0], hs_tag[0], hs_data[0]} !== {4'd2, 23'h44, DF}) begin n_fail++; $display("FAIL b2b_payload: got set=%0h tag=%0h want set=2 tag=44", hs_set[0], hs_tag[0]); end
    n_checks++; if (d !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d want 1", d); end
  endtask

  task automatic test_flush;
    int b, h, d, u, hb;
    access(4'd0, 23'h10, 1'b0, DA, 1'b1);
    access(4'd0, 23'h11, 1'b0, DB, 1'b1);
    access(4'd0, 23'h22, 1'b1, DX, 1'b1);
    access(4'd15, 23'h30, 1'b0, DA, 1'b1);
    access(4'd15, 23'h31, 1'b0, DB, 1'b1);
    access(4'd15, 23'h32, 1'b0, DC, 1'b1);
    access(4'd15, 23'h33, 1'b1, DY, 1'b1);
    pulse_flush();
    watch_flush(0, b, h, d, u, hb);
    n_checks++; if (b !== 66) begin n_fail++; $display("FAIL flush_busy: got %0d want 66", b); end
    n_checks++; if (h !== 2) begin n_fail++; $display("FAIL flush_hs_count: got %0d want 2", h); end
    n_checks++; if ({hs_set[0], hs_tag[0], hs_data[0]} !== {4'd0, 23'h22, DX}) begin n_fail++; $display("FAIL flush_hs0: got set=%0h tag=%0h want set=0 tag=22", hs_set[0], hs_tag[0]); end
    n_checks++; if ({hs_set[1], hs_tag[1], hs_data[1]} !== {4'd15, 23'h33, DY}) begin n_fail++; $display("FAIL flush_hs1: got set=%0h tag=%0h want set=f tag=33", hs_set[1], hs_tag[1]); end
    n_checks++; if (d !== 1) begin n_fail++; $display("FAIL flush_done: got %0d want 1", d); end
    lookup(4'd0, 23'h22);
    n_checks++; if ({hit_o, way_o, tag_o} !== {1'b1, 2'd2, 2'b10, 23'h22}) begin n_fail++; $display("FAIL flush_clean0: got hit=%0h way=%0h tag=%0h", hit_o, way_o, tag_o); end
    lookup(4'd15, 23'h33);
    n_checks++; if ({hit_o, way_o, tag_o} !== {1'b1, 2'd3, 2'b10, 23'h33}) begin n_fail++; $display("FAIL flush_clean15: got hit=%0h way=%0h tag=%0h", hit_o, way_o, tag_o); end
  endtask

  task automatic test_stall;
    int b, h, d, u, hb;
    access(4'd0, 23'h22, 1'b1, DX2, 1'b1);
    pulse_flush();
    addr = 4'd5; tag_in = {2'b00, 23'h1}; data_in = DZ; write = 1'b1; enable = 1'b1;
    watch_flush(5, b, h, d, u, hb);
    enable = 1'b0; write = 1'b0;
    n_checks++; if (b !== 70) begin n_fail++; $display("FAIL stall_busy: got %0d want 70", b); end
    n_checks++; if (h !== 1) begin n_fail++; $display("FAIL stall_hs_count: got %0d want 1", h); end
    n_checks++; if ({hs_set[0], hs_tag[0], hs_data[0]} !== {4'd0, 23'h22, DX2}) begin n_fail++; $display("FAIL stall_payload: got set=%0h tag=%0h want set=0 tag=22", hs_set[0], hs_tag[0]); end
    n_checks++; if (u !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", u); end
    n_checks++; if (hb !== 0) begin n_fail++; $display("FAIL stall_hit_busy: got %0d want 0", hb); end
    n_checks++; if (d !== 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", d); end
    lookup(4'd5, 23'h1);
    n_checks++; if ({hit_o, data_o} !== {1'b1, DA}) begin n_fail++; $display("FAIL stall_write_ignored: got hit=%0h data=%0h want hit=1 data A", hit_o, data_o); end
  endtask

  task automatic test_reset_mid_flush;
    logic found;
    int dn, wv;
    access(4'd0, 23'h22, 1'b1, DX, 1'b1);
    wb_ready = 1'b0;
    pulse_flush();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (wb_valid_o) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstwb_reach_wb: got %0h want 1", found); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({busy_o, wb_valid_o, flush_done_o} !== 3'b000) begin n_fail++; $display("FAIL rstwb_outputs: got busy=%0h wbv=%0h done=%0h want 0", busy_o, wb_valid_o, flush_done_o); end
    @(negedge clk); rst = 1'b0;
    dn = 0; wv = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (flush_done_o) dn++;
      if (wb_valid_o || busy_o) wv++;
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL rstwb_no_done: got %0d want 0", dn); end
    n_checks++; if (wv !== 0) begin n_fail++; $display("FAIL rstwb_idle: got %0d want 0", wv); end
    lookup(4'd0, 23'h22);
    n_checks++; if ({hit_o, tag_o, data_o} !== {1'b0, 25'h0, 256'h0}) begin n_fail++; $display("FAIL rstwb_set0: got hit=%0h tag=%0h", hit_o, tag_o); end
    lookup(4'd5, 23'h1);
    n_checks++; if ({hit_o, tag_o} !== {1'b0, 25'h0}) begin n_fail++; $display("FAIL rstwb_set5: got hit=%0h tag=%0h", hit_o, tag_o); end
    lookup(4'd15, 23'h33);
    n_checks++; if ({hit_o, tag_o} !== {1'b0, 25'h0}) begin n_fail++; $display("FAIL rstwb_set15: got hit=%0h tag=%0h", hit_o, tag_o); end
    wb_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lru();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
